// File: rtl/mult_serial_host.sv
// Host for the bit-serial multiplier: operand in, LSB-first serial run, parallel product out; `MULT_HOST_FLUSH_EN adds a post-reset zero drain.
// Product valid 2*WIDTH+1 cycles after the start handshake; DONE holds product until result_ready, start_ready only in IDLE.
module mult_serial_host #(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [WIDTH-1:0]   mcand,
    output logic               ser_bit,
    input  logic               ser_prod,
    output logic               result_valid,
    input  logic               result_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CW = $clog2(2 * WIDTH);
    localparam logic [CW-1:0] LAST = CW'(2 * WIDTH - 1);

    typedef enum logic [1:0] {FLUSH, IDLE, RUN, DONE} state_t;

`ifdef MULT_HOST_FLUSH_EN
    localparam state_t RST_STATE = FLUSH;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic               ser_bit_q, ser_bit_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               result_valid_q, result_valid_d;
    logic               start_ready_q, start_ready_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mcand_d        = mcand_q;
        b_sr_d         = b_sr_q;
        ser_bit_d      = ser_bit_q;
        product_d      = product_q;
        result_valid_d = result_valid_q;
        case (state_q)
`ifdef MULT_HOST_FLUSH_EN
            FLUSH: begin
                mcand_d   = '0;
                ser_bit_d = 1'b0;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
`endif
            IDLE: begin
                if (start_valid && start_ready_q) begin
                    mcand_d   = op_a;
                    b_sr_d    = {1'b0, op_b[WIDTH-1:1]};
                    ser_bit_d = op_b[0];
                    cnt_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Zeros shifted into b_sr make the second half of the run a drain.
                product_d = {ser_prod, product_q[2*WIDTH-1:1]};
                ser_bit_d = b_sr_q[0];
                b_sr_d    = b_sr_q >> 1;
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    ser_bit_d = 1'b0;
                    mcand_d   = '0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (result_valid_q && result_ready) begin
                    result_valid_d = 1'b0;
                    state_d        = IDLE;
                end else begin
                    result_valid_d = 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase
        start_ready_d = (state_d == IDLE);
        busy_d        = (state_d == FLUSH) || (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= RST_STATE;
            cnt_q          <= '0;
            mcand_q        <= '0;
            b_sr_q         <= '0;
            ser_bit_q      <= 1'b0;
            product_q      <= '0;
            result_valid_q <= 1'b0;
            start_ready_q  <= (RST_STATE == IDLE);
            busy_q         <= (RST_STATE == FLUSH);
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            mcand_q        <= mcand_d;
            b_sr_q         <= b_sr_d;
            ser_bit_q      <= ser_bit_d;
            product_q      <= product_d;
            result_valid_q <= result_valid_d;
            start_ready_q  <= start_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign start_ready  = start_ready_q;
    assign mcand        = mcand_q;
    assign ser_bit      = ser_bit_q;
    assign result_valid = result_valid_q;
    assign product      = product_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_mult_serial_host.sv
// Directed bench for mult_serial_host with an echo stub and a serial-parallel multiplier model.
module tb_mult_serial_host;
    localparam int W = 16;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [W-1:0]   op_a = '0;
    logic [W-1:0]   op_b = '0;
    logic [W-1:0]   mcand;
    logic           ser_bit;
    logic           ser_prod;
    logic           result_valid;
    logic           result_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic       use_echo  = 1'b1;
    logic       model_clr = 1'b1;
    logic [W:0] acc;
    logic [W:0] sum;

`ifdef MULT_HOST_FLUSH_EN
    localparam logic [W:0] JUNK = 17'h0ABCD;
`else
    localparam logic [W:0] JUNK = '0;
`endif

    always #5 clock = ~clock;

    // Serial-parallel multiplier: accumulator adds mcand when ser_bit is set, emits LSB, shifts right.
    assign sum      = acc + {1'b0, (ser_bit ? mcand : {W{1'b0}})};
    assign ser_prod = use_echo ? ser_bit : sum[0];
    always_ff @(posedge clock) acc <= model_clr ? JUNK : (sum >> 1);

    mult_serial_host #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .mcand(mcand), .ser_bit(ser_bit), .ser_prod(ser_prod),
        .result_valid(result_valid), .result_ready(result_ready),
        .product(product), .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        logic ok;
        @(negedge clock);
        reset = 1'b1; model_clr = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0; model_clr = 1'b0;
        chk({tag, "_rv"}, result_valid, 1'b0);
        chk({tag, "_prod"}, product, 32'h0);
        chk({tag, "_mcand"}, mcand, 16'h0);
`ifdef MULT_HOST_FLUSH_EN
        ok = 1'b1;
        for (int i = 0; i < 2 * W; i++) begin
            if (start_ready || ser_bit || mcand != 0 || !busy || result_valid) ok = 1'b0;
            @(posedge clock);
            @(negedge clock);
        end
        chk({tag, "_flush_hold"}, ok, 1'b1);
        chk({tag, "_ready_after_flush"}, start_ready, 1'b1);
        chk({tag, "_idle_busy"}, busy, 1'b0);
`else
        ok = 1'b1;
        chk({tag, "_ready_now"}, start_ready, ok);
        chk({tag, "_idle_busy"}, busy, 1'b0);
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!start_ready && n < 200) begin
            @(posedge clock);
            @(negedge clock);
            n++;
        end
        if (!start_ready) chk({tag, "_ready_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp, input int hold, input logic churn,
                          output logic [2*W-1:0] seq);
        int got;
        logic ok;
        logic [2*W-1:0] p0;
        seq = '0;
        wait_ready(tag);
        start_valid = 1'b1; op_a = a; op_b = b;
        @(posedge clock);
        @(negedge clock);
        if (!churn) start_valid = 1'b0;
        seq[0] = ser_bit;
        chk({tag, "_mcand_run"}, mcand, a);
        chk({tag, "_busy_run"}, busy, 1'b1);
        got = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clock);
            @(negedge clock);
            if (n < 2 * W) seq[n] = ser_bit;
            if (churn) op_b = W'($urandom);
            if (result_valid) begin
                got = n;
                break;
            end
        end
        chk({tag, "_latency"}, got, 2 * W + 1);
        chk({tag, "_product"}, product, exp);
        chk({tag, "_done_ready"}, start_ready, 1'b0);
        chk({tag, "_done_drive"}, {mcand, ser_bit, busy}, '0);
        start_valid = 1'b0;
        ok = 1'b1;
        p0 = product;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            if (product !== p0 || !result_valid || start_ready) ok = 1'b0;
        end
        if (hold > 0) chk({tag, "_hold_stable"}, ok, 1'b1);
        result_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        result_ready = 1'b0;
        chk({tag, "_rv_drop"}, result_valid, 1'b0);
        chk({tag, "_idle_ready"}, start_ready, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [2*W-1:0] seq;
        int rv_seen;

        do_reset("rst");

        use_echo = 1'b1;
        run_op("echo", 16'h0001, 16'hA5C3, 32'h0000A5C3, 0, 1'b0, seq);
        chk("echo_ser_seq", seq, 32'h0000A5C3);

        use_echo = 1'b0;
        run_op("mul3x5", 16'h0003, 16'h0005, 32'd15, 0, 1'b0, seq);
        run_op("mulffffx1", 16'hFFFF, 16'h0001, 32'h0000FFFF, 0, 1'b0, seq);
        run_op("mulmax", 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, 1'b0, seq);

        run_op("bp", 16'h1234, 16'h0010, 32'h00012340, 10, 1'b0, seq);

        // Abort at RUN cycle 7.
        wait_ready("abort");
        start_valid = 1'b1; op_a = 16'h0055; op_b = 16'h00AA;
        @(posedge clock);
        @(negedge clock);
        start_valid = 1'b0;
        repeat (7) @(posedge clock);
        do_reset("abort_rst");
        rv_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (result_valid) rv_seen++;
            @(posedge clock);
            @(negedge clock);
        end
        chk("abort_no_rv", rv_seen, 0);
        run_op("mul7x9", 16'h0007, 16'h0009, 32'd63, 0, 1'b0, seq);

        run_op("churn", 16'h0002, 16'h0011, 32'h00000022, 0, 1'b1, seq);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mult_serial_host.md
Name: mult_serial_host

Overview:
Host-side driver and collector for the bit-serial 16-bit multiplier. It accepts a parallel operand pair over a valid/ready handshake and holds the multiplicand on the multiplier's parallel inputs. It shifts the multiplier operand into the serial input LSB-first, then shifts in zeros to drain the array. It deserialises the serial product stream into a parallel 2*WIDTH-bit word and returns it over a second valid/ready handshake.

Parameters:
WIDTH, 16, operand width in bits; product width is 2*WIDTH; the serial run length is 2*WIDTH cycles.

Ports:
clock  input  1  single system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start_valid  input  1  operand pair offered
start_ready  output  1  host can accept operands; high only in IDLE
op_a  input  WIDTH  multiplicand, captured on start handshake
op_b  input  WIDTH  serial multiplier operand, captured on start handshake
mcand  output  WIDTH  parallel multiplicand to multiplier; registered
ser_bit  output  1  serial operand bit to multiplier; registered
ser_prod  input  1  serial product bit from multiplier (combinational on multiplier side)
result_valid  output  1  product available
result_ready  input  1  consumer accepts product
product  output  2*WIDTH  collected product word
busy  output  1  high in FLUSH or RUN

Behaviour:
- States: FLUSH, IDLE, RUN, DONE. Counter cnt is clog2(2*WIDTH) bits wide.
- Reset behaviour: state=FLUSH with the optional feature compiled in, otherwise IDLE. cnt=0, mcand=0, ser_bit=0, product=0, result_valid=0, start_ready=0 (1 if entering IDLE), busy=1 in FLUSH.
- FLUSH: mcand=0, ser_bit=0 for exactly 2*WIDTH cycles to drain the unreset multiplier registers. ser_prod is ignored. Transition to IDLE when cnt==2*WIDTH-1; cnt returns to 0.
- IDLE: start_ready=1. On start_valid & start_ready:
  - capture op_a into mcand and op_b into shift register b_sr.
  - drive ser_bit=op_b[0] in the next cycle.
  - cnt=0; go to RUN.
- RUN, cycle k = 0..2*WIDTH-1:
  - ser_bit = b_sr[k] for k<WIDTH, else 0.
  - mcand holds op_a.
  - ser_prod is sampled in the same cycle k and written into product[k], i.e. a right-shift into the MSB gives LSB-first assembly.
  - After cycle k=2*WIDTH-1: go to DONE, result_valid=1, ser_bit=0, mcand=0.
- DONE: product is held stable and result_valid stays high until result_ready. On result_valid & result_ready, go to IDLE and drop result_valid the next cycle.
- Back-to-back: a new start is accepted no earlier than the cycle after the result handshake. The drain half of RUN leaves the multiplier at zero, so no FLUSH is needed between operations.
- start_valid during FLUSH, RUN or DONE is ignored (start_ready=0). Operands must be held by the source until accepted.
- result_ready while result_valid=0 has no effect.
- Reset asserted mid-RUN or mid-DONE aborts the operation: the pending product is discarded and result_valid drops the next cycle. The state enters FLUSH (or IDLE), and the flush guarantees the multiplier is clean.
- Latency: start handshake at edge T. ser_bit carries op_b[0] during cycle T+1. result_valid is high from edge T+2*WIDTH+1.
- Output signals are registered; none depend combinationally on inputs.

Optional Feature:
MULT_HOST_FLUSH_EN:
- Defined: reset enters FLUSH and performs 2*WIDTH zero-drive cycles before start_ready rises, so start_ready is first high 2*WIDTH cycles after reset deasserts.
- Undefined: the FLUSH state and its logic are removed, reset enters IDLE directly, and start_ready is high the first cycle after reset. The system must then guarantee the multiplier starts cleared.

Test Plan:
1. Reset with flush (WIDTH=16): start_ready=0 and ser_bit=0, mcand=0 for 32 cycles after reset deassert -> start_ready=1 on cycle 33; busy high throughout the flush.
2. Stub multiplier echoing ser_bit back on ser_prod, op_a=0x0001, op_b=0xA5C3:
   - ser_bit sequence is 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 followed by 16 zeros.
   - product=0x0000A5C3; result_valid rises 33 cycles after the start edge.
3. Real multiplier model, op_a=3, op_b=5 -> product=15; then op_a=0xFFFF, op_b=1 -> product matches the model for both operations, with no flush between them.
4. Backpressure: hold result_ready=0 for 10 cycles in DONE -> product and result_valid stable, start_ready=0; raise result_ready -> IDLE the next cycle.
5. Reset asserted at RUN cycle 7 -> result_valid never rises for that operation; FLUSH repeats; the next operation op_a=7, op_b=9 gives product=63.
6. start_valid held high continuously with a changing op_b while busy -> only the value present at the IDLE handshake is used.
